fetch: RTL
==========

# fetch

Instruction fetch stage with IF/ID pipeline register. Holds the program counter and issues word requests to instruction memory over a valid/request handshake. Presents each returned instruction to the decode stage together with its PC and a valid bit. Honours stalls from the hazard logic and redirects (taken branch/jump) from execute, dropping any wrong-path response that is still in flight.

## Interface
Parameters:
- XLEN, 32, datapath and address width
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- F_stall  in  1  hold the IF/ID register; decode cannot accept a new instruction
- F_redirect  in  1  redirect fetch to F_target this cycle
- F_target  in  XLEN  redirect address; bits [1:0] ignored, treated as 0
- imem_req  out  1  request outstanding; imem_addr valid
- imem_addr  out  XLEN  word-aligned fetch address
- imem_valid  in  1  imem_rdata valid; completes the outstanding request
- imem_rdata  in  XLEN  returned instruction word
- D_inst  out  XLEN  instruction to decode (IF/ID register)
- D_pc  out  XLEN  address of D_inst
- D_pc4  out  XLEN  D_pc + 4, modulo 2^XLEN
- D_valid  out  1  D_inst/D_pc hold a real instruction; 0 = bubble

## Operation
- Registers: state, fetch_pc (address of the current request), redir_pc, buf_inst/buf_pc (one-entry buffer), D_inst, D_pc, D_valid.
- States: FETCH (imem_req=1, imem_addr=fetch_pc), BUF (imem_req=0, response held in buffer), DRAIN (imem_req=1, imem_addr=fetch_pc, response is wrong-path and will be discarded).
- imem_req is 0 while rst=1. imem_addr must stay stable while imem_req=1 until imem_valid. Only one request is outstanding at a time.
- ID accept: the IF/ID register accepts a new instruction when F_stall=0 or D_valid=0.
- FETCH, imem_valid=1, no redirect, ID accept: D_inst<=imem_rdata, D_pc<=fetch_pc, D_valid<=1, fetch_pc<=fetch_pc+4, stay in FETCH.
- FETCH, imem_valid=1, no redirect, no ID accept: buf_inst<=imem_rdata, buf_pc<=fetch_pc, fetch_pc<=fetch_pc+4, go to BUF. ID register holds.
- FETCH, imem_valid=0, no ID accept: ID register holds.
- FETCH, imem_valid=0, ID accept: D_valid<=0.
- BUF, F_stall=0, no redirect: D_inst<=buf_inst, D_pc<=buf_pc, D_valid<=1, go to FETCH.
- BUF, F_stall=1: hold everything.
- Redirect has priority over stall and over any response. Any state with F_redirect=1: D_valid<=0 and the buffer is discarded.
  - FETCH with imem_valid=1: response is discarded; fetch_pc<=target; stay in FETCH.
  - FETCH with imem_valid=0: redir_pc<=target; go to DRAIN.
  - BUF: fetch_pc<=target; go to FETCH.
  - DRAIN: redir_pc<=target, overwriting any earlier target.
- DRAIN, imem_valid=1: response is discarded; fetch_pc<=redir_pc, or <=F_target if F_redirect=1 in that same cycle; go to FETCH. D_valid stays 0.
- DRAIN, imem_valid=0: remain in DRAIN. While in DRAIN, D_valid<=0 whenever ID accept holds.
- D_pc4 is combinational from D_pc. PC arithmetic wraps modulo 2^XLEN with no fault.

## Timing
- Reset values: state=FETCH, fetch_pc=RESET_PC, redir_pc=0, D_valid=0, D_inst=0, D_pc=0, buffer=0.
- First request: imem_req=1, imem_addr=RESET_PC in the first cycle after rst deasserts.
- imem_valid may be asserted in the same cycle the request is first presented (zero-wait memory). Peak throughput is one instruction per cycle.
- Latency: a response accepted in cycle N appears on D_* in cycle N+1, and the next address is presented in cycle N+1.
- Redirect in cycle N, no request in flight: imem_addr=target in cycle N+1. D_valid=0 in cycle N+1.
- Redirect with a request in flight: the target is requested the cycle after the old response arrives.
- rst asserted in any state, including DRAIN or BUF: all registers return to reset values on the next edge. Any in-flight response arriving afterwards is the memory's responsibility; the memory is reset together with this block.

## Test plan
- Reset, zero-wait memory returning addr-derived words -> imem_addr 0,4,8,12 in consecutive cycles; D_pc follows one cycle later; D_valid=1 continuously; D_pc4=D_pc+4.
- F_stall=1 for 3 cycles while D_valid=1, memory responds at addr 0x10 -> D_* frozen; block enters BUF with imem_req=0. On release, 0x10 appears on D_pc next cycle, then request 0x14.
- 3-wait-state memory -> each instruction takes 4 cycles; D_valid=0 between them; imem_addr stable for all 4 cycles of each request.
- Redirect to 0x200 one cycle into a 3-wait request at 0x40 -> imem_addr stays 0x40 until valid; that response is never seen on D_*; next imem_addr=0x200.
- Redirect to 0x103 in the same cycle as imem_valid -> response dropped; D_valid=0 next cycle; next imem_addr=0x100.
- fetch_pc=0xFFFFFFFC with XLEN=32 -> D_pc4=0; next imem_addr=0. Also: rst asserted while in DRAIN -> next imem_addr=RESET_PC and D_valid=0.

Source files
------------

// File: rtl/fetch.sv
// fetch: instruction fetch stage with IF/ID register, one-entry skid buffer and wrong-path drain.
module fetch #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            F_stall,
  input  logic            F_redirect,
  input  logic [XLEN-1:0] F_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] D_inst,
  output logic [XLEN-1:0] D_pc,
  output logic [XLEN-1:0] D_pc4,
  output logic            D_valid
);
  typedef enum logic [1:0] {FETCH, BUF, DRAIN} state_t;
  state_t          state_q;
  logic [XLEN-1:0] fetch_pc_q, redir_pc_q, buf_inst_q, buf_pc_q, d_inst_q, d_pc_q;
  logic            d_valid_q;
  logic [XLEN-1:0] tgt, pc_inc;
  logic            accept;
  assign tgt       = F_target & ~XLEN'(3);
  assign pc_inc    = fetch_pc_q + XLEN'(4);
  assign accept    = !F_stall || !d_valid_q;
  assign imem_req  = !rst && state_q != BUF;
  assign imem_addr = fetch_pc_q;
  assign D_inst    = d_inst_q;
  assign D_pc      = d_pc_q;
  assign D_pc4     = d_pc_q + XLEN'(4);
  assign D_valid   = d_valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      redir_pc_q <= '0;
      buf_inst_q <= '0;
      buf_pc_q   <= '0;
      d_inst_q   <= '0;
      d_pc_q     <= '0;
      d_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH:
          if (F_redirect) begin
            d_valid_q <= 1'b0;
            if (imem_valid) fetch_pc_q <= tgt;
            else begin
              redir_pc_q <= tgt;
              state_q    <= DRAIN;
            end
          end else if (imem_valid) begin
            fetch_pc_q <= pc_inc;
            if (accept) begin
              d_inst_q  <= imem_rdata;
              d_pc_q    <= fetch_pc_q;
              d_valid_q <= 1'b1;
            end else begin
              buf_inst_q <= imem_rdata;
              buf_pc_q   <= fetch_pc_q;
              state_q    <= BUF;
            end
          end else if (accept) d_valid_q <= 1'b0;
        BUF:
          if (F_redirect) begin
            d_valid_q  <= 1'b0;
            fetch_pc_q <= tgt;
            state_q    <= FETCH;
          end else if (!F_stall) begin
            d_inst_q  <= buf_inst_q;
            d_pc_q    <= buf_pc_q;
            d_valid_q <= 1'b1;
            state_q   <= FETCH;
          end
        DRAIN: begin
          // DRAIN is only entered through a redirect, so the ID register is already a bubble
          d_valid_q <= 1'b0;
          if (F_redirect) redir_pc_q <= tgt;
          if (imem_valid) begin
            fetch_pc_q <= F_redirect ? tgt : redir_pc_q;
            state_q    <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end
endmodule
